// File: rtl/ddc_quad_mixer_pkg.sv
// Shared DDC constants: default widths, NCO latency, product width and saturation limits.
package ddc_quad_mixer_pkg;

  localparam int DDC_DATA_WIDTH   = 16;
  localparam int DDC_NCO_WIDTH    = 16;
  localparam int DDC_OUTPUT_WIDTH = 16;
  localparam int DDC_NCO_LATENCY  = 2;

  localparam int DDC_SAT_MAX = 2 ** (DDC_OUTPUT_WIDTH - 1) - 1;
  localparam int DDC_SAT_MIN = -(2 ** (DDC_OUTPUT_WIDTH - 1));

  function automatic int prod_width(input int data_w, input int nco_w);
    return data_w + nco_w;
  endfunction

  localparam int DDC_PROD_WIDTH = prod_width(DDC_DATA_WIDTH, DDC_NCO_WIDTH);

endpackage

// File: rtl/ddc_quad_mixer_if.sv
// Sample/NCO/IQ bus of the quadrature mixer; slave is the mixer, master is its environment.
interface ddc_quad_mixer_if
  import ddc_quad_mixer_pkg::*;
#(
  parameter int DATA_WIDTH   = DDC_DATA_WIDTH,
  parameter int NCO_WIDTH    = DDC_NCO_WIDTH,
  parameter int OUTPUT_WIDTH = DDC_OUTPUT_WIDTH
);
  logic signed [DATA_WIDTH-1:0]   adcData;
  logic                           adcValid;
  logic                           ncoEnable;
  logic signed [NCO_WIDTH-1:0]    sinIn;
  logic signed [NCO_WIDTH-1:0]    cosIn;
  logic signed [OUTPUT_WIDTH-1:0] iOut;
  logic signed [OUTPUT_WIDTH-1:0] qOut;
  logic                           outValid;

  modport master (
    output adcData, adcValid, sinIn, cosIn,
    input  ncoEnable, iOut, qOut, outValid
  );

  modport slave (
    input  adcData, adcValid, sinIn, cosIn,
    output ncoEnable, iOut, qOut, outValid
  );
endinterface

// File: rtl/ddc_round_sat.sv
// One mixer rail: stage R shift (rounding when MIXER_ROUND_EN is defined), stage S saturate.
module ddc_round_sat #(
  parameter int PROD_WIDTH   = 32,
  parameter int OUTPUT_WIDTH = 16,
  parameter int BASE_SHIFT   = 15
) (
  input  logic                           CLK,
  input  logic                           nRST,
  input  logic                           ldR_i,
  input  logic                           ldS_i,
  input  logic signed [PROD_WIDTH-1:0]   prod_i,
  input  logic [1:0]                     shSel_i,
  output logic signed [OUTPUT_WIDTH-1:0] value_o,
  output logic                           sat_o
);
  // One extra bit so the rounding offset cannot wrap the largest product.
  localparam int WW = PROD_WIDTH + 1;
  localparam logic signed [WW-1:0] MAX_W = (WW'(1) <<< (OUTPUT_WIDTH - 1)) - WW'(1);
  localparam logic signed [WW-1:0] MIN_W = -(WW'(1) <<< (OUTPUT_WIDTH - 1));

  logic signed [WW-1:0]           scaled_p2_q;
  logic signed [OUTPUT_WIDTH-1:0] value_p3_q;
  logic                           sat_p3_q;

  function automatic logic signed [WW-1:0] round_shift(input logic signed [PROD_WIDTH-1:0] p,
                                                       input logic [1:0] sel);
    int sh;
    logic signed [WW-1:0] w;
    sh = BASE_SHIFT - int'(sel);
    w  = WW'(p);
`ifdef MIXER_ROUND_EN
    w  = w + (WW'(1) <<< (sh - 1));
`endif
    return w >>> sh;
  endfunction

  function automatic logic signed [OUTPUT_WIDTH-1:0] saturate(input logic signed [WW-1:0] w);
    if (w > MAX_W)      return MAX_W[OUTPUT_WIDTH-1:0];
    else if (w < MIN_W) return MIN_W[OUTPUT_WIDTH-1:0];
    else                return w[OUTPUT_WIDTH-1:0];
  endfunction

  function automatic logic is_sat(input logic signed [WW-1:0] w);
    return (w > MAX_W) || (w < MIN_W);
  endfunction

  // Stage R
  always_ff @(posedge CLK) begin
    if (ldR_i) scaled_p2_q <= round_shift(prod_i, shSel_i);
  end

  // Stage S
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      value_p3_q <= '0;
      sat_p3_q   <= 1'b0;
    end else if (ldS_i) begin
      value_p3_q <= saturate(scaled_p2_q);
      sat_p3_q   <= is_sat(scaled_p2_q);
    end
  end

  assign value_o = value_p3_q;
  assign sat_o   = sat_p3_q;
endmodule

// File: rtl/ddc_quad_mixer.sv
// Quadrature down-mixer: ADC x NCO cos/(-sin), NCO-latency alignment, scale/round/saturate, sat counter.
// Rounding is selected by the MIXER_ROUND_EN macro (truncation when undefined).
module ddc_quad_mixer
  import ddc_quad_mixer_pkg::*;
#(
  parameter int DATA_WIDTH    = DDC_DATA_WIDTH,
  parameter int NCO_WIDTH     = DDC_NCO_WIDTH,
  parameter int OUTPUT_WIDTH  = DDC_OUTPUT_WIDTH,
  parameter int NCO_LATENCY   = DDC_NCO_LATENCY,
  parameter int SAT_CNT_WIDTH = 16
) (
  input  logic                     CLK,
  input  logic                     nRST,
  ddc_quad_mixer_if.slave          bus,
  input  logic [1:0]               shiftSel,
  input  logic                     satClr,
  output logic [SAT_CNT_WIDTH-1:0] satCount
);
  localparam int PW      = prod_width(DATA_WIDTH, NCO_WIDTH);
  localparam int BASE_SH = PW - 1 - OUTPUT_WIDTH;

  logic [NCO_LATENCY-1:0]       alnVld_q;
  logic signed [DATA_WIDTH-1:0] alnData_q [NCO_LATENCY];
  logic                         vld_p1_q, vld_p2_q, vld_p3_q;
  logic signed [PW-1:0]         prodI_p1_q, prodQ_p1_q;
  logic [1:0]                   sh_p1_q;
  logic signed [OUTPUT_WIDTH-1:0] iVal, qVal;
  logic                         satI, satQ;
  logic [SAT_CNT_WIDTH-1:0]     satCnt_q, satCnt_d;

  // The NCO advances exactly once per accepted sample.
  assign bus.ncoEnable = bus.adcValid;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      alnVld_q <= '0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
      satCnt_q <= '0;
    end else begin
      alnVld_q[0] <= bus.adcValid;
      for (int k = 1; k < NCO_LATENCY; k++) alnVld_q[k] <= alnVld_q[k-1];
      vld_p1_q <= alnVld_q[NCO_LATENCY-1];
      vld_p2_q <= vld_p1_q;
      vld_p3_q <= vld_p2_q;
      satCnt_q <= satCnt_d;
    end
  end

  // Align stage
  always_ff @(posedge CLK) begin
    if (bus.adcValid) alnData_q[0] <= bus.adcData;
    for (int k = 1; k < NCO_LATENCY; k++) begin
      if (alnVld_q[k-1]) alnData_q[k] <= alnData_q[k-1];
    end
  end

  // Stage M
  always_ff @(posedge CLK) begin
    if (alnVld_q[NCO_LATENCY-1]) begin
      prodI_p1_q <= PW'(alnData_q[NCO_LATENCY-1]) * PW'(bus.cosIn);
      prodQ_p1_q <= -(PW'(alnData_q[NCO_LATENCY-1]) * PW'(bus.sinIn));
      sh_p1_q    <= shiftSel;
    end
  end

  ddc_round_sat #(.PROD_WIDTH(PW), .OUTPUT_WIDTH(OUTPUT_WIDTH), .BASE_SHIFT(BASE_SH)) u_rail_i (
    .CLK(CLK), .nRST(nRST), .ldR_i(vld_p1_q), .ldS_i(vld_p2_q),
    .prod_i(prodI_p1_q), .shSel_i(sh_p1_q), .value_o(iVal), .sat_o(satI)
  );

  ddc_round_sat #(.PROD_WIDTH(PW), .OUTPUT_WIDTH(OUTPUT_WIDTH), .BASE_SHIFT(BASE_SH)) u_rail_q (
    .CLK(CLK), .nRST(nRST), .ldR_i(vld_p1_q), .ldS_i(vld_p2_q),
    .prod_i(prodQ_p1_q), .shSel_i(sh_p1_q), .value_o(qVal), .sat_o(satQ)
  );

  // Clear wins over a coincident hit; the count sticks at all-ones.
  always_comb begin
    satCnt_d = satCnt_q;
    if (satClr)
      satCnt_d = '0;
    else if (vld_p3_q && (satI || satQ) && (satCnt_q != '1))
      satCnt_d = satCnt_q + SAT_CNT_WIDTH'(1);
  end

  assign bus.iOut     = iVal;
  assign bus.qOut     = qVal;
  assign bus.outValid = vld_p3_q;
  assign satCount     = satCnt_q;
endmodule

// File: tb/tb_ddc_quad_mixer.sv
// Bench for ddc_quad_mixer: NCO model with latency, arithmetic reference, cycle-exact output queue.
module tb_ddc_quad_mixer;
  import ddc_quad_mixer_pkg::*;

  localparam int DW  = DDC_DATA_WIDTH;
  localparam int NW  = DDC_NCO_WIDTH;
  localparam int OW  = DDC_OUTPUT_WIDTH;
  localparam int L   = DDC_NCO_LATENCY;
  localparam int SCW = 16;
  localparam longint CNT_MAX = (longint'(1) << SCW) - 1;

  logic           CLK = 1'b0;
  logic           nRST = 1'b0;
  logic [1:0]     shiftSel;
  logic           satClr;
  logic [SCW-1:0] satCount;

  ddc_quad_mixer_if #(.DATA_WIDTH(DW), .NCO_WIDTH(NW), .OUTPUT_WIDTH(OW)) mix ();

  ddc_quad_mixer #(
    .DATA_WIDTH(DW), .NCO_WIDTH(NW), .OUTPUT_WIDTH(OW), .NCO_LATENCY(L), .SAT_CNT_WIDTH(SCW)
  ) dut (
    .CLK(CLK), .nRST(nRST), .bus(mix), .shiftSel(shiftSel), .satClr(satClr), .satCount(satCount)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    longint cyc;
    longint i;
    longint q;
    bit     sat;
  } exp_t;

  exp_t   expq[$];
  int     ncmp = 0;
  int     nerr = 0;
  longint cyc = 0;
  longint modelCnt = 0;
  longint lastI = 0, lastQ = 0;
  bit     monVld = 0, monSat = 0;
  bit     rv[16];
  int     rs[16], rc[16], rsh[16];

  task automatic chk(input string tag, input logic signed [63:0] got, input longint expv);
    ncmp++;
    assert (got === expv)
    else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, expv);
    end
  endtask

  // Divide by 2^sh rounding toward minus infinity, optional half-LSB bias first.
  function automatic longint scale(input longint p, input int sh);
    longint d, r;
    d = longint'(1) << sh;
`ifdef MIXER_ROUND_EN
    p = p + d / 2;
`endif
    r = p / d;
    if ((p % d != 0) && (p < 0)) r = r - 1;
    return r;
  endfunction

  function automatic longint clamp(input longint v, output bit hit);
    longint hi, lo;
    hi  = (longint'(1) << (OW - 1)) - 1;
    lo  = -(longint'(1) << (OW - 1));
    hit = (v > hi) || (v < lo);
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  task automatic cycle();
    longint nxt;
    int     slot;
    bit     ev;
    exp_t   e;
    if (!nRST || satClr) nxt = 0;
    else if (monVld && monSat && modelCnt != CNT_MAX) nxt = modelCnt + 1;
    else nxt = modelCnt;
    @(posedge CLK);
    #1;
    cyc++;
    modelCnt = nxt;
    slot = int'(cyc % 16);
    if (rv[slot]) begin
      mix.sinIn = NW'(rs[slot]);
      mix.cosIn = NW'(rc[slot]);
      shiftSel  = 2'(rsh[slot]);
      rv[slot]  = 1'b0;
    end else begin
      mix.sinIn = NW'($urandom);
      mix.cosIn = NW'($urandom);
      shiftSel  = 2'($urandom);
    end
    while (expq.size() > 0 && expq[0].cyc < cyc) void'(expq.pop_front());
    ev = (expq.size() > 0) && (expq[0].cyc == cyc);
    chk("outValid", mix.outValid, longint'(ev));
    if (ev) begin
      e = expq.pop_front();
      lastI = e.i;
      lastQ = e.q;
      monSat = e.sat;
    end else begin
      monSat = 1'b0;
    end
    monVld = ev;
    chk("iOut", mix.iOut, lastI);
    chk("qOut", mix.qOut, lastQ);
    chk("satCount", satCount, modelCnt);
  endtask

  task automatic issue(input int a, input int s, input int c, input int sel);
    exp_t e;
    bit   hi, hq;
    int   slot;
    mix.adcData  = DW'(a);
    mix.adcValid = 1'b1;
    slot = int'((cyc + L) % 16);
    rv[slot]  = 1'b1;
    rs[slot]  = s;
    rc[slot]  = c;
    rsh[slot] = sel;
    e.cyc = cyc + L + 3;
    e.i   = clamp(scale(longint'(a) * c, DW + NW - 1 - OW - sel), hi);
    e.q   = clamp(scale(-(longint'(a) * s), DW + NW - 1 - OW - sel), hq);
    e.sat = hi | hq;
    expq.push_back(e);
    #1 chk("ncoEnable", mix.ncoEnable, 1);
    cycle();
  endtask

  task automatic idle();
    mix.adcValid = 1'b0;
    mix.adcData  = DW'($urandom);
    #1 chk("ncoEnable", mix.ncoEnable, 0);
    cycle();
  endtask

  function automatic int rnd(input int w);
    return int'($urandom_range((1 << w) - 1, 0)) - (1 << (w - 1));
  endfunction

  initial begin
    satClr = 1'b0;
    shiftSel = 2'd0;
    mix.adcValid = 1'b0;
    mix.adcData = '0;
    mix.sinIn = '0;
    mix.cosIn = '0;
    repeat (3) idle();
    chk("rst_outValid", mix.outValid, 0);
    chk("rst_iOut", mix.iOut, 0);
    chk("rst_satCount", satCount, 0);
    nRST = 1'b1;
    repeat (2) idle();

    // Directed corners
    issue(16384, 0, 32767, 0);
    repeat (L + 4) idle();
`ifdef MIXER_ROUND_EN
    chk("round_half_i", lastI, 16384);
`else
    chk("round_half_i", lastI, 16383);
`endif
    chk("round_half_sat", satCount, 0);
    issue(32767, 0, 32767, 1);
    repeat (L + 4) idle();
    chk("pos_sat_i", lastI, DDC_SAT_MAX);
    chk("pos_sat_cnt", satCount, 1);
    issue(-32768, -32768, -32768, 0);
    repeat (L + 4) idle();
    chk("neg_corner_q", lastQ, DDC_SAT_MIN);
    chk("neg_corner_cnt", satCount, 2);

    // Streaming with a 3-cycle gap
    for (int k = 0; k < 64; k++) issue(rnd(DW), rnd(NW), rnd(NW), int'($urandom_range(3, 0)));
    repeat (3) idle();
    for (int k = 0; k < 20; k++) issue(rnd(DW), rnd(NW), rnd(NW), int'($urandom_range(3, 0)));

    // Random valid pattern
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(1, 0) == 1) issue(rnd(DW), rnd(NW), rnd(NW), int'($urandom_range(3, 0)));
      else idle();
    end
    repeat (L + 4) idle();

    // Counter fill, hold and clear priority
    for (int k = 0; k < 65540; k++) issue(32767, 0, 32767, 3);
    repeat (L + 4) idle();
    chk("cnt_hold", satCount, CNT_MAX);
    for (int r = 0; r < 2; r++) begin
      issue(32767, 0, 32767, 3);
      repeat (L + 2) idle();
      chk("clr_setup_vld", mix.outValid, 1);
      satClr = 1'b1;
      idle();
      satClr = 1'b0;
      chk("clr_priority", satCount, 0);
    end
    repeat (L + 4) idle();

    // Reset with samples in flight
    for (int k = 0; k < 3; k++) issue(32767, 32767, 32767, 3);
    #2 nRST = 1'b0;
    #1;
    expq.delete();
    for (int k = 0; k < 16; k++) rv[k] = 1'b0;
    lastI = 0;
    lastQ = 0;
    modelCnt = 0;
    monVld = 1'b0;
    monSat = 1'b0;
    chk("midrst_outValid", mix.outValid, 0);
    chk("midrst_iOut", mix.iOut, 0);
    chk("midrst_qOut", mix.qOut, 0);
    chk("midrst_satCount", satCount, 0);
    repeat (2) idle();
    nRST = 1'b1;
    repeat (12) idle();
    issue(rnd(DW), rnd(NW), rnd(NW), 2);

    for (int k = 0; k < 40 && expq.size() > 0; k++) idle();
    chk("drain_empty", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
